// File: rtl/mdr_mem_if.sv
// Memory data register with a built-in read/write handshake controller.
// Handles byte/half/word lanes, sign/zero extension, write replication and timeout.
module mdr_mem_if #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15,
  localparam int LANE_W = $clog2(WIDTH / 8)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     bus_in,
  input  logic                 mdr_in,
  input  logic                 read,
  input  logic                 write,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [LANE_W-1:0]    addr_lo,
  input  logic [WIDTH-1:0]     mem_in,
  input  logic                 mem_ready,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [WIDTH-1:0]     mem_out,
  output logic [WIDTH/8-1:0]   mem_be,
  output logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int NB    = WIDTH / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [1:0]          size_q, size_next;
  logic                sign_q, sign_next;
  logic [LANE_W-1:0]   lane_q, lane_next;
  logic [WIDTH-1:0]    q_next, mem_out_next, rd_data, wr_data;
  logic [NB-1:0]       mem_be_next, wr_be;
  logic                mem_rd_next, mem_wr_next, busy_next, done_next, err_next;
  logic                bad_access;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;

  always_comb begin
    bad_access = 1'b0;
    case (size)
      2'b00:   bad_access = (addr_lo != '0);
      2'b01:   bad_access = addr_lo[0];
      2'b10:   bad_access = 1'b0;
      default: bad_access = 1'b1;
    endcase
  end

  // Read lane extraction uses the lane/size/sign latched at transaction start.
  always_comb begin
    rd_byte = mem_in[{lane_q, 3'b000} +: 8];
    rd_half = mem_in[{lane_q[LANE_W-1:1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   rd_data = mem_in;
      2'b01:   rd_data = {{(WIDTH-16){sign_q & rd_half[15]}}, rd_half};
      default: rd_data = {{(WIDTH-8){sign_q & rd_byte[7]}}, rd_byte};
    endcase
  end

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NB; i++) begin
      case (size)
        2'b00:   wr_data[8*i +: 8] = Q[8*i +: 8];
        2'b01:   wr_data[8*i +: 8] = Q[8*(i%2) +: 8];
        default: wr_data[8*i +: 8] = Q[7:0];
      endcase
    end
    case (size)
      2'b00:   wr_be = '1;
      2'b01:   wr_be = NB'(3) << addr_lo;
      default: wr_be = NB'(1) << addr_lo;
    endcase
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    size_next    = size_q;
    sign_next    = sign_q;
    lane_next    = lane_q;
    q_next       = Q;
    mem_out_next = mem_out;
    mem_be_next  = mem_be;
    mem_rd_next  = mem_rd;
    mem_wr_next  = mem_wr;
    busy_next    = busy;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state)
      IDLE: begin
        if (read && write) begin
          err_next = 1'b1;
        end else if ((read || write) && bad_access) begin
          err_next = 1'b1;
        end else if (read || write) begin
          state_next  = read ? RD_WAIT : WR_WAIT;
          mem_rd_next = read;
          mem_wr_next = write;
          busy_next   = 1'b1;
          cnt_next    = '0;
          size_next   = size;
          sign_next   = sign_ext;
          lane_next   = addr_lo;
          if (write) begin
            mem_out_next = wr_data;
            mem_be_next  = wr_be;
          end
        end else if (mdr_in) begin
          q_next = bus_in;
        end
      end
      RD_WAIT, WR_WAIT: begin
        cnt_next = cnt + CNT_W'(1);
        // Completion and timeout share the same exit path; only Q handling differs.
        if (mem_ready || (TIMEOUT != 0 && int'(cnt) + 1 == TIMEOUT)) begin
          state_next   = IDLE;
          mem_rd_next  = 1'b0;
          mem_wr_next  = 1'b0;
          busy_next    = 1'b0;
          mem_out_next = '0;
          mem_be_next  = '0;
          done_next    = mem_ready;
          err_next     = !mem_ready;
          if (mem_ready && state == RD_WAIT) q_next = rd_data;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      cnt     <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      lane_q  <= '0;
      Q       <= '0;
      mem_out <= '0;
      mem_be  <= '0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      size_q  <= size_next;
      sign_q  <= sign_next;
      lane_q  <= lane_next;
      Q       <= q_next;
      mem_out <= mem_out_next;
      mem_be  <= mem_be_next;
      mem_rd  <= mem_rd_next;
      mem_wr  <= mem_wr_next;
      busy    <= busy_next;
      done    <= done_next;
      err     <= err_next;
    end
  end

endmodule
